// File: rtl/edge_arb_pkg.sv
// Shared types and the round-robin pick function for the edge event arbiter.
package edge_arb_pkg;

  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_e;
  typedef enum logic {IDLE, PRESENT} state_e;

  localparam int MAX_CH = 16;

  // First pending channel after ptr, wrapping at n; returns 0 when nothing is pending.
  function automatic int rr_pick(input logic [MAX_CH-1:0] pend, input int ptr, input int n);
    int   idx;
    logic found;
    rr_pick = 0;
    found   = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      if (i <= n && !found) begin
        idx = (ptr + i) % n;
        if (pend[idx[3:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: edge detection, a single-entry pending slot with polarity, and a sticky overflow flag.
module edge_chan
  import edge_arb_pkg::*;
#(
  parameter edge_mode_e EDGE_MODE = EDGE_BOTH
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic grant,
  input  logic clr_overflow,
  output logic pending,
  output logic pol,
  output logic overflow
);

  logic level_q;
  logic rise;
  logic fall;
  logic det;

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

  always_comb begin
    case (EDGE_MODE)
      EDGE_RISE: det = rise;
      EDGE_FALL: det = fall;
      default:   det = rise | fall;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q  <= level;
      pending  <= 1'b0;
      pol      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      level_q <= level;
      // A grant frees the slot this same edge, so a coincident edge refills it instead of overflowing.
      if (det && (!pending || grant)) begin
        pending <= 1'b1;
        pol     <= rise;
      end else if (grant) begin
        pending <= 1'b0;
      end
      if (det && pending && !grant)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge queues merged onto one valid/ready event stream in round-robin order.
//   state   | meaning
//   IDLE    | no event presented; load a winner as soon as anything is pending
//   PRESENT | evt_ch/evt_rise held valid until the consumer takes them
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter edge_mode_e EDGE_MODE = EDGE_BOTH,
  parameter int         CHW       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CHW-1:0]  evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] overflow,
  input  logic            clr_overflow
);

  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   pol;
  logic [N_CH-1:0]   grant;
  logic [MAX_CH-1:0] pend_ext;
  logic [CHW-1:0]    rr_ptr;
  logic [CHW-1:0]    pick;
  logic              load;
  state_e            state;

  always_comb begin
    pend_ext            = '0;
    pend_ext[N_CH-1:0]  = pending;
  end

  assign pick = CHW'(rr_pick(pend_ext, int'(rr_ptr), N_CH));
  // Loading on a handshake keeps the stream back-to-back with no idle bubble.
  assign load = (|pending) && ((state == IDLE) || evt_ready);

  always_comb begin
    grant = '0;
    if (load) grant[pick] = 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_chan #(.EDGE_MODE(EDGE_MODE)) u_chan (
      .clk          (clk),
      .reset        (reset),
      .level        (level[i]),
      .grant        (grant[i]),
      .clr_overflow (clr_overflow),
      .pending      (pending[i]),
      .pol          (pol[i]),
      .overflow     (overflow[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      rr_ptr    <= CHW'(N_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state     <= PRESENT;
            evt_valid <= 1'b1;
            evt_ch    <= pick;
            evt_rise  <= pol[pick];
            rr_ptr    <= pick;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            if (load) begin
              evt_ch   <= pick;
              evt_rise <= pol[pick];
              rr_ptr   <= pick;
            end else begin
              state     <= IDLE;
              evt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random traffic against an event-level model.
module tb_edge_event_arbiter;
  import edge_arb_pkg::*;

  localparam int N   = 4;
  localparam int CHW = 2;
  localparam int OW  = N + CHW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  level;
  logic          evt_valid;
  logic          evt_ready;
  logic [CHW-1:0] evt_ch;
  logic          evt_rise;
  logic [N-1:0]  overflow;
  logic          clr_overflow;

  logic [N-1:0]  level_f;
  logic          evt_valid_f;
  logic [CHW-1:0] evt_ch_f;
  logic          evt_rise_f;
  logic [N-1:0]  overflow_f;

  int vectors = 0;
  int errors  = 0;

  edge_event_arbiter #(.N_CH(N), .EDGE_MODE(EDGE_BOTH)) dut (
    .clk(clk), .reset(reset), .level(level), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_rise(evt_rise), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  edge_event_arbiter #(.N_CH(N), .EDGE_MODE(EDGE_FALL)) dut_f (
    .clk(clk), .reset(reset), .level(level_f), .evt_valid(evt_valid_f), .evt_ready(1'b1),
    .evt_ch(evt_ch_f), .evt_rise(evt_rise_f), .overflow(overflow_f), .clr_overflow(1'b0)
  );

  always #5 clk = ~clk;

  // Reference model: one queued event per channel, one presented event, last-served channel.
  logic [N-1:0]   m_prev, m_pend, m_pol, m_ovf;
  logic           m_v;
  logic [CHW-1:0] m_ch;
  logic           m_rise;
  int             m_last;

  logic [OW-1:0] got;
  assign got = {evt_valid, evt_ch, evt_rise, overflow};

  function automatic logic [OW-1:0] expv();
    return {m_v, m_ch, m_rise, m_ovf};
  endfunction

  task automatic model_step();
    int g;
    logic hs;
    logic [N-1:0] setv, newpol, lost;
    if (reset) begin
      m_prev = level; m_pend = '0; m_pol = '0; m_ovf = '0;
      m_v = 1'b0; m_ch = '0; m_rise = 1'b0; m_last = N - 1;
      return;
    end
    g  = -1;
    hs = m_v && evt_ready;
    if (!m_v || hs) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    setv = '0; newpol = '0; lost = '0;
    for (int i = 0; i < N; i++) begin
      logic r, f;
      r = level[i] && !m_prev[i];
      f = !level[i] && m_prev[i];
      if (r || f) begin
        if (m_pend[i] && g != i) lost[i] = 1'b1;
        else begin setv[i] = 1'b1; newpol[i] = r; end
      end
    end
    if (clr_overflow) m_ovf = '0;
    m_ovf = m_ovf | lost;
    if (g >= 0) begin
      m_v = 1'b1; m_ch = CHW'(g); m_rise = m_pol[g]; m_pend[g] = 1'b0; m_last = g;
    end else if (hs) begin
      m_v = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (setv[i]) begin m_pend[i] = 1'b1; m_pol[i] = newpol[i]; end
    m_prev = level;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; level = 4'b0100; evt_ready = 1'b1; clr_overflow = 1'b0; level_f = '0;
    tick(); tick();
    vectors++;
    if (got !== '0) begin errors++; $display("FAIL reset_state: got %h expected %h", got, '0); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (evt_valid !== 1'b0 || got !== expv()) begin
        errors++; $display("FAIL reset_level_high: got %h expected %h", got, expv());
      end
    end
  endtask

  task automatic test_single_edge();
    for (int p = 0; p < 2; p++) begin
      level[0] = (p == 0);
      tick();
      vectors++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_lat1: got %b expected 0", evt_valid); end
      tick();
      vectors++;
      if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, (p == 0)}) begin
        errors++; $display("FAIL single_evt: got %b expected %b", {evt_valid, evt_ch, evt_rise}, {1'b1, 2'd0, (p == 0)});
      end
      tick();
      vectors++;
      if (got !== expv() || evt_valid !== 1'b0) begin
        errors++; $display("FAIL single_done: got %h expected %h", got, expv());
      end
    end
  endtask

  task automatic test_burst();
    reset = 1'b1; level = '0; tick();
    reset = 1'b0; tick();
    level = 4'b1111; tick();
    for (int c = 0; c < N; c++) begin
      tick();
      vectors++;
      if ({evt_valid, evt_ch, evt_rise} !== {1'b1, CHW'(c), 1'b1} || got !== expv()) begin
        errors++; $display("FAIL burst_ch%0d: got %h expected %h", c, got, expv());
      end
    end
    tick();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL burst_end: got %b expected 0", evt_valid); end
  endtask

  task automatic test_back_pressure();
    int seen;
    evt_ready = 1'b0;
    level[1] = 1'b0; tick(); tick();
    level[1] = 1'b1; tick();
    level[1] = 1'b0; tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({evt_valid, evt_ch, evt_rise} !== 4'b1010 || got !== expv()) begin
        errors++; $display("FAIL hold: got %h expected %h", got, expv());
      end
    end
    vectors++;
    if (overflow !== 4'b0010) begin errors++; $display("FAIL overflow_set: got %b expected 0010", overflow); end
    evt_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (evt_valid && evt_ch == 2'd1) seen++;
      tick();
      vectors++;
      if (got !== expv()) begin errors++; $display("FAIL drain: got %h expected %h", got, expv()); end
    end
    vectors++;
    if (seen !== 2) begin errors++; $display("FAIL ch1_count: got %0d expected 2", seen); end
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    vectors++;
    if (overflow !== 4'b0000) begin errors++; $display("FAIL overflow_clr: got %b expected 0000", overflow); end
  endtask

  task automatic test_fairness();
    evt_ready = 1'b1;
    level[2] = ~level[2]; tick(); tick(); tick();
    level = level ^ 4'b1001; tick();
    tick();
    vectors++;
    if ({evt_valid, evt_ch} !== 3'b111) begin errors++; $display("FAIL fair_first: got %b expected 111", {evt_valid, evt_ch}); end
    tick();
    vectors++;
    if ({evt_valid, evt_ch} !== 3'b100 || got !== expv()) begin
      errors++; $display("FAIL fair_second: got %h expected %h", got, expv());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    level[1] = ~level[1]; tick(); tick();
    level[3] = ~level[3]; tick();
    reset = 1'b1; tick();
    vectors++;
    if (evt_valid !== 1'b0 || got !== expv()) begin errors++; $display("FAIL reset_mid: got %h expected %h", got, expv()); end
    reset = 1'b0; evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL after_reset: got %b expected 0", evt_valid); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] mask;
      for (int i = 0; i < N; i++) mask[i] = ($urandom_range(0, 5) == 0);
      level        = level ^ mask;
      evt_ready    = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      tick();
      vectors++;
      if (got !== expv()) begin errors++; $display("FAIL random_%0d: got %h expected %h", n, got, expv()); end
    end
    clr_overflow = 1'b0;
  endtask

  task automatic test_fall_mode();
    evt_ready = 1'b1;
    level_f[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (evt_valid_f !== 1'b0) begin errors++; $display("FAIL fall_rise_ignored: got %b expected 0", evt_valid_f); end
    end
    level_f[0] = 1'b0;
    tick();
    vectors++;
    if (evt_valid_f !== 1'b0) begin errors++; $display("FAIL fall_lat1: got %b expected 0", evt_valid_f); end
    tick();
    vectors++;
    if ({evt_valid_f, evt_ch_f, evt_rise_f} !== 4'b1000) begin
      errors++; $display("FAIL fall_evt: got %b expected 1000", {evt_valid_f, evt_ch_f, evt_rise_f});
    end
    tick();
    vectors++;
    if (evt_valid_f !== 1'b0) begin errors++; $display("FAIL fall_done: got %b expected 0", evt_valid_f); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_burst();
    test_back_pressure();
    test_fairness();
    test_reset_mid();
    test_random();
    test_fall_mode();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
